// File: rtl/jtopl_pkg.sv
// Shared OPL register map constants and timer-control field positions.
package jtopl_pkg;

  localparam logic [7:0] REG_T1   = 8'h02;
  localparam logic [7:0] REG_T2   = 8'h03;
  localparam logic [7:0] REG_TCTL = 8'h04;
  localparam logic [7:0] REG_CSM  = 8'h08;

  // Bit positions inside register 0x04
  localparam int unsigned IRQRST = 7;
  localparam int unsigned MASK1  = 6;
  localparam int unsigned MASK2  = 5;
  localparam int unsigned ST2    = 1;
  localparam int unsigned ST1    = 0;

  // Bit position of the CSM enable inside register 0x08
  localparam int unsigned CSM_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_BUSY = 2'd1,
    ST_DATA_BUSY = 2'd2
  } busy_state_e;

endpackage

// File: rtl/jtopl_busy.sv
// Post-write busy timer: counts cen ticks after each accepted CPU write.
module jtopl_busy
  import jtopl_pkg::*;
#(
  parameter int unsigned CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_i,
  input  logic          start_i,
  input  busy_state_e   kind_i,
  input  logic [CW-1:0] wait_len_i,
  output logic          busy_o
);

  busy_state_e   state_q;
  logic [CW-1:0] cnt_q;

  // A new write always restarts the wait; otherwise count down on cen and drop to idle at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (start_i) begin
      state_q <= kind_i;
      cnt_q   <= wait_len_i;
    end else if (cen_i && (state_q != ST_IDLE)) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q <= CW'(1)) begin
        state_q <= ST_IDLE;
      end
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/jtopl_timer_ctrl.sv
// CPU write decoder for the OPL timer registers, status byte, IRQ and busy flag.
module jtopl_timer_ctrl
  import jtopl_pkg::*;
#(
  parameter int unsigned ADDR_WAIT = 12,
  parameter int unsigned DATA_WAIT = 84,
  parameter int unsigned CW        = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen_i,
  input  logic       cs_n_i,
  input  logic       wr_n_i,
  input  logic       a0_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       busy_o,
  output logic [7:0] value_A_o,
  output logic [7:0] value_B_o,
  output logic       load_A_o,
  output logic       load_B_o,
  output logic       clr_flag_A_o,
  output logic       clr_flag_B_o,
  output logic       flagen_A_o,
  output logic       flagen_B_o,
  input  logic       flag_A_i,
  input  logic       flag_B_i,
  input  logic       overflow_A_i,
  output logic       irq_n_o,
  output logic       csm_en_o,
  output logic       csm_keyon_o,
  output logic       reg_wr_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_din_o
);

  logic       we_q, we_dly_q, a0_q;
  logic [7:0] din_q;
  logic       wr_ev_c;

  logic [7:0] reg_addr_q, reg_din_q, value_A_q, value_B_q, dout_q;
  logic       load_A_q, load_B_q, flagen_A_q, flagen_B_q;
  logic       clr_A_q, clr_B_q, csm_en_q, csm_keyon_q, reg_wr_q;

  // Register the bus so one write strobe produces exactly one event on its rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      we_dly_q <= 1'b0;
      a0_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      we_q     <= ~cs_n_i & ~wr_n_i;
      we_dly_q <= we_q;
      a0_q     <= a0_i;
      din_q    <= din_i;
    end
  end

  assign wr_ev_c = we_q & ~we_dly_q;

  // Address latch, timer register decode, forwarding, status byte and CSM key-on
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_addr_q  <= '0;
      reg_din_q   <= '0;
      value_A_q   <= '0;
      value_B_q   <= '0;
      load_A_q    <= 1'b0;
      load_B_q    <= 1'b0;
      flagen_A_q  <= 1'b1;
      flagen_B_q  <= 1'b1;
      clr_A_q     <= 1'b0;
      clr_B_q     <= 1'b0;
      csm_en_q    <= 1'b0;
      csm_keyon_q <= 1'b0;
      reg_wr_q    <= 1'b0;
      dout_q      <= '0;
    end else begin
      clr_A_q     <= 1'b0;
      clr_B_q     <= 1'b0;
      reg_wr_q    <= 1'b0;
      csm_keyon_q <= csm_en_q & overflow_A_i & cen_i;
      dout_q      <= {flag_A_i | flag_B_i, flag_A_i, flag_B_i, 5'b0};
      if (wr_ev_c) begin
        if (!a0_q) begin
          reg_addr_q <= din_q;
        end else begin
          case (reg_addr_q)
            REG_T1: value_A_q <= din_q;
            REG_T2: value_B_q <= din_q;
            REG_TCTL: begin
              if (din_q[IRQRST]) begin
                // IRQ reset only; masks and start bits are left alone
                clr_A_q <= 1'b1;
                clr_B_q <= 1'b1;
              end else begin
                flagen_A_q <= ~din_q[MASK1];
                flagen_B_q <= ~din_q[MASK2];
                load_A_q   <= din_q[ST1];
                load_B_q   <= din_q[ST2];
              end
            end
            default: begin
              // 0x08 lands here too: the other bits belong to the synth
              reg_wr_q  <= 1'b1;
              reg_din_q <= din_q;
              if (reg_addr_q == REG_CSM) begin
                csm_en_q <= din_q[CSM_BIT];
              end
            end
          endcase
        end
      end
    end
  end

  jtopl_busy #(
    .CW (CW)
  ) u_busy (
    .clk        (clk),
    .rst        (rst),
    .cen_i      (cen_i),
    .start_i    (wr_ev_c),
    .kind_i     (a0_q ? ST_DATA_BUSY : ST_ADDR_BUSY),
    .wait_len_i (a0_q ? CW'(DATA_WAIT) : CW'(ADDR_WAIT)),
    .busy_o     (busy_o)
  );

  assign irq_n_o      = ~(flag_A_i | flag_B_i);
  assign dout_o       = dout_q;
  assign value_A_o    = value_A_q;
  assign value_B_o    = value_B_q;
  assign load_A_o     = load_A_q;
  assign load_B_o     = load_B_q;
  assign clr_flag_A_o = clr_A_q;
  assign clr_flag_B_o = clr_B_q;
  assign flagen_A_o   = flagen_A_q;
  assign flagen_B_o   = flagen_B_q;
  assign csm_en_o     = csm_en_q;
  assign csm_keyon_o  = csm_keyon_q;
  assign reg_wr_o     = reg_wr_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_din_o    = reg_din_q;

endmodule

// File: tb/tb_jtopl_timer_ctrl.sv
// Directed bench for jtopl_timer_ctrl: write decode, flags/IRQ, CSM, busy timing and reset.
module tb_jtopl_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen_i = 1'b0;
  logic       cs_n_i = 1'b1;
  logic       wr_n_i = 1'b1;
  logic       a0_i = 1'b0;
  logic [7:0] din_i = '0;
  logic       flag_A_i = 1'b0;
  logic       flag_B_i = 1'b0;
  logic       overflow_A_i = 1'b0;

  logic [7:0] dout_o, value_A_o, value_B_o, reg_addr_o, reg_din_o;
  logic       busy_o, load_A_o, load_B_o, clr_flag_A_o, clr_flag_B_o;
  logic       flagen_A_o, flagen_B_o, irq_n_o, csm_en_o, csm_keyon_o, reg_wr_o;

  int checks = 0;
  int errors = 0;

  jtopl_timer_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cen_i        (cen_i),
    .cs_n_i       (cs_n_i),
    .wr_n_i       (wr_n_i),
    .a0_i         (a0_i),
    .din_i        (din_i),
    .dout_o       (dout_o),
    .busy_o       (busy_o),
    .value_A_o    (value_A_o),
    .value_B_o    (value_B_o),
    .load_A_o     (load_A_o),
    .load_B_o     (load_B_o),
    .clr_flag_A_o (clr_flag_A_o),
    .clr_flag_B_o (clr_flag_B_o),
    .flagen_A_o   (flagen_A_o),
    .flagen_B_o   (flagen_B_o),
    .flag_A_i     (flag_A_i),
    .flag_B_i     (flag_B_i),
    .overflow_A_i (overflow_A_i),
    .irq_n_o      (irq_n_o),
    .csm_en_o     (csm_en_o),
    .csm_keyon_o  (csm_keyon_o),
    .reg_wr_o     (reg_wr_o),
    .reg_addr_o   (reg_addr_o),
    .reg_din_o    (reg_din_o)
  );

  always #5 clk = ~clk;

  // cen high on every other clock, changed 2 time units after the rising edge
  always begin
    @(posedge clk);
    #2 cen_i = ~cen_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe on the given port
  task automatic wr(input logic a0, input logic [7:0] d);
    @(negedge clk);
    cs_n_i = 1'b0;
    wr_n_i = 1'b0;
    a0_i   = a0;
    din_i  = d;
    @(negedge clk);
    cs_n_i = 1'b1;
    wr_n_i = 1'b1;
  endtask

  // Count cen ticks seen while busy, starting at the current falling edge
  task automatic measure(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy_o) break;
      if (cen_i) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int pulses;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", dout_o, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_value_A", value_A_o, 8'h00);
    chk("rst_value_B", value_B_o, 8'h00);
    chk("rst_loads", {load_A_o, load_B_o}, 2'b00);
    chk("rst_flagen", {flagen_A_o, flagen_B_o}, 2'b11);
    chk("rst_pulses", {clr_flag_A_o, clr_flag_B_o, reg_wr_o, csm_keyon_o}, 4'b0000);
    chk("rst_csm_en", csm_en_o, 1'b0);
    chk("rst_reg_addr", reg_addr_o, 8'h00);
    chk("rst_irq_n", irq_n_o, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Address write then timer 1 preset, with busy lengths
    wr(1'b0, 8'h02);
    @(negedge clk);
    chk("addr02_latch", reg_addr_o, 8'h02);
    chk("addr02_busy", busy_o, 1'b1);
    measure(n);
    chk("addr_wait_len", n, 12);
    wr(1'b1, 8'hF0);
    @(negedge clk);
    chk("value_A_F0", value_A_o, 8'hF0);
    chk("t1_no_fwd", reg_wr_o, 1'b0);
    measure(n);
    chk("data_wait_len", n, 84);

    // Timer 2 preset leaves timer 1 alone
    wr(1'b0, 8'h03);
    wr(1'b1, 8'h5A);
    @(negedge clk);
    chk("value_B_5A", value_B_o, 8'h5A);
    chk("value_A_kept", value_A_o, 8'hF0);

    // Start timer 1
    wr(1'b0, 8'h04);
    wr(1'b1, 8'h01);
    @(negedge clk);
    chk("st1_loads", {load_A_o, load_B_o}, 2'b10);
    chk("st1_flagen", {flagen_A_o, flagen_B_o}, 2'b11);

    // Timer 1 flag raises IRQ and status
    flag_A_i = 1'b1;
    #1 chk("flagA_irq_n", irq_n_o, 1'b0);
    @(negedge clk);
    chk("flagA_dout", dout_o, 8'hC0);

    // IRQ reset: one-clock clear pulses, nothing else touched
    wr(1'b0, 8'h04);
    wr(1'b1, 8'h80);
    @(negedge clk);
    chk("irqrst_clr", {clr_flag_A_o, clr_flag_B_o}, 2'b11);
    flag_A_i = 1'b0;
    #1 chk("irqrst_irq_n", irq_n_o, 1'b1);
    @(negedge clk);
    chk("irqrst_clr_once", {clr_flag_A_o, clr_flag_B_o}, 2'b00);
    chk("irqrst_load_kept", load_A_o, 1'b1);
    chk("irqrst_flagen_kept", {flagen_A_o, flagen_B_o}, 2'b11);
    chk("irqrst_dout", dout_o, 8'h00);

    // Mask timer 1 and stop it
    wr(1'b0, 8'h04);
    wr(1'b1, 8'h40);
    @(negedge clk);
    chk("mask1_flagen", {flagen_A_o, flagen_B_o}, 2'b01);
    chk("mask1_loads", {load_A_o, load_B_o}, 2'b00);
    chk("mask1_irq_n", irq_n_o, 1'b1);

    // Overflow before CSM is enabled: no key-on
    for (int i = 0; i < 4 && !cen_i; i++) @(negedge clk);
    overflow_A_i = 1'b1;
    @(negedge clk);
    overflow_A_i = 1'b0;
    chk("keyon_off", csm_keyon_o, 1'b0);

    // CSM enable, forwarded, then a single key-on pulse
    wr(1'b0, 8'h08);
    wr(1'b1, 8'h80);
    @(negedge clk);
    chk("csm_fwd_wr", reg_wr_o, 1'b1);
    chk("csm_fwd_addr", reg_addr_o, 8'h08);
    chk("csm_fwd_din", reg_din_o, 8'h80);
    chk("csm_en", csm_en_o, 1'b1);
    @(negedge clk);
    chk("csm_fwd_once", reg_wr_o, 1'b0);
    for (int i = 0; i < 4 && !cen_i; i++) @(negedge clk);
    overflow_A_i = 1'b1;
    @(negedge clk);
    overflow_A_i = 1'b0;
    chk("keyon_pulse", csm_keyon_o, 1'b1);
    @(negedge clk);
    chk("keyon_once", csm_keyon_o, 1'b0);

    // Held strobe yields exactly one forwarded write
    wr(1'b0, 8'h20);
    @(negedge clk);
    cs_n_i = 1'b0;
    wr_n_i = 1'b0;
    a0_i   = 1'b1;
    din_i  = 8'h33;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (reg_wr_o) pulses++;
      if (i == 3) begin
        cs_n_i = 1'b1;
        wr_n_i = 1'b1;
      end
    end
    chk("held_strobe_pulses", pulses, 1);
    chk("held_strobe_din", reg_din_o, 8'h33);

    // Data write during address busy is accepted and restarts the long wait
    wr(1'b0, 8'hA0);
    wr(1'b1, 8'h55);
    @(negedge clk);
    chk("busy_wr_fwd", reg_wr_o, 1'b1);
    chk("busy_wr_addr", reg_addr_o, 8'hA0);
    chk("busy_wr_din", reg_din_o, 8'h55);
    measure(n);
    chk("restart_wait_len", n, 84);

    // Reset in the middle of a wait
    wr(1'b0, 8'h10);
    @(negedge clk);
    chk("pre_rst_busy", busy_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_value_A", value_A_o, 8'h00);
    chk("mid_rst_csm_en", csm_en_o, 1'b0);
    chk("mid_rst_addr", reg_addr_o, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
